moore_pattern_tx: RTL
=====================

Name: moore_pattern_tx

Overview:
- Serial pattern transmitter: loads a WIDTH-bit word and emits it MSB-first, one bit per clock, on a single serial line.
- Moore FSM: every output is a function of state registers only.
- Drives the serial Input of the team's Moore sequence detectors, in bench and in system.
- Gives a synthesizable, cycle-exact stimulus source in place of hand-written bit toggling.

Parameters:
- WIDTH, 4, bits per word; legal range 2..16.
- GAP_CYCLES, 1, idle cycles (Output=0, Frame=0) after each word; 0 is legal.

Ports:
- Clk  input  1  system clock, all logic on rising edge.
- Rst  input  1  synchronous, active-high reset.
- Data  input  WIDTH  word to transmit; sampled only on an accepted Start.
- Start  input  1  load request.
- Ready  output  1  high only in IDLE; Start && Ready is an accepted load.
- Output  output  1  serial bit, MSB first.
- Frame  output  1  high while Output carries a word (or parity) bit.
- Done  output  1  one-cycle pulse after the frame and its gap complete.

Behaviour:
- One clock (Clk); reset is synchronous and active-high (Rst); both fixed.
- Reset, checked on the clock edge, overrides everything:
  - state=IDLE; shift register and bit counter cleared.
  - Output=0, Frame=0, Done=0, Ready=1 from the first cycle after the reset edge.
- Reset mid-frame aborts the word: no Done pulse and no remaining bits.
- States:
  - IDLE: Ready=1, Output=0. On Start at an edge: shreg<=Data, cnt<=0, go to SHIFT.
  - SHIFT: Output=shreg[WIDTH-1], Frame=1. Each edge: shreg<=shreg<<1, cnt<=cnt+1.
  - SHIFT exit, at the edge where cnt==WIDTH-1: go to PARITY if enabled, else GAP when GAP_CYCLES>0, else DONE.
  - GAP: Output=0, Frame=0; stays GAP_CYCLES cycles (own counter), then goes to DONE.
  - DONE: Done=1 for exactly one cycle, Ready=0, then goes to IDLE.
- Latency:
  - First bit is on Output in the cycle immediately after the accepting edge.
  - Frame lasts exactly WIDTH cycles (WIDTH+1 with parity).
  - Start to Done = WIDTH + GAP_CYCLES (+1 parity) + 1 cycles.
  - Minimum word-to-word period is WIDTH+GAP_CYCLES+2 cycles.
- Start outside IDLE is ignored and not queued.
- Data changes after acceptance do not affect the word in flight.
- Start held high continuously gives back-to-back words, one per minimum period, each sampling Data in IDLE.
- Counter widths: cnt is $clog2(WIDTH) bits, gap counter is $clog2(GAP_CYCLES+1) bits; no wrap-around is reachable.
- Encoding: binary, 3 bits. Unused codes go to IDLE with Output=0.

Optional Feature:
- Macro MOORE_PATTERN_TX_PARITY_EN.
- Defined: a PARITY state is added after SHIFT:
  - Output = XOR of the loaded word (even parity), Frame=1, one cycle.
  - Parity is computed at load and held in its own register.
- Undefined: no PARITY state and no parity register; SHIFT goes straight to GAP or DONE.

Decomposition:
- Shared package moore_pkg holds:
  - state encoding localparams (S_IDLE=0, S_SHIFT=1, S_PARITY=2, S_GAP=3, S_DONE=4);
  - default WIDTH and GAP_CYCLES constants, shared with the detector blocks.
- No sub-module is required; the shift register and counters live inline in one always block, with a separate output-decode block.

Test Plan:
- Reset, then Start with Data=4'b1011 (GAP_CYCLES=1): Output=1,0,1,1 on cycles 1-4 after the accepting edge; Frame high in exactly those 4 cycles; gap on cycle 5; Done on cycle 6; Ready=1 on cycle 7.
- Start held high with Data=1011 then Data=0110: serial stream 1011 0 0110 0, with the idle-cycle spacing and no lost or duplicated bit. Detector-compatible pattern check.
- Start pulsed in SHIFT cycle 2 with different Data: ignored; frame bits unchanged; no second frame.
- Rst asserted in SHIFT cycle 3: next cycle Output=0, Frame=0, Ready=1, no Done pulse; a new Start works normally.
- With MOORE_PATTERN_TX_PARITY_EN, Data=4'b1011: bits 1,0,1,1,1 with Frame high 5 cycles. With Data=4'b1001 the parity bit is 0.
- GAP_CYCLES=0, WIDTH=8, Data=8'hA5: bits 1,0,1,0,0,1,0,1, then Done the next cycle, then Ready.

Source files
------------

// File: rtl/moore_pattern_tx_pkg.sv
// Shared encodings and defaults for the Moore pattern transmitter and the
// sequence detectors it feeds.
package moore_pkg;

    localparam int DEF_WIDTH      = 4;
    localparam int DEF_GAP_CYCLES = 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SHIFT  = 3'd1;
    localparam logic [2:0] S_PARITY = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_SHIFT  = S_SHIFT,
        ST_PARITY = S_PARITY,
        ST_GAP    = S_GAP,
        ST_DONE   = S_DONE
    } state_t;

endpackage

// File: rtl/moore_pattern_tx_if.sv
// Load handshake plus serial output bundle of the pattern transmitter.
// The transmitter takes the slave side; whoever supplies words takes master.
interface moore_pattern_tx_if
    import moore_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] Data;
    logic             Start;
    logic             Ready;
    logic             Output;
    logic             Frame;
    logic             Done;

    modport master (output Data, Start, input Ready, Output, Frame, Done);
    modport slave  (input Data, Start, output Ready, Output, Frame, Done);
endinterface

// File: rtl/moore_pattern_tx.sv
// Moore serial pattern transmitter: WIDTH-bit word out MSB-first, optional
// even-parity bit (MOORE_PATTERN_TX_PARITY_EN), GAP_CYCLES idle, Done pulse.
module moore_pattern_tx
    import moore_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic              Clk,
    input  logic              Rst,
    moore_pattern_tx_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LAST_I);
    // Where the word ends up once its data bits (and parity) have gone out.
    localparam state_t POST_WORD = (GAP_CYCLES > 0) ? ST_GAP : ST_DONE;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic [GW-1:0]    r_gcnt;
`ifdef MOORE_PATTERN_TX_PARITY_EN
    logic             r_parity;
`endif

    logic w_ready;
    logic w_out;
    logic w_frame;
    logic w_done;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state  <= ST_IDLE;
            r_shreg  <= '0;
            r_cnt    <= '0;
            r_gcnt   <= '0;
`ifdef MOORE_PATTERN_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.Start) begin
                        r_shreg  <= bus.Data;
                        r_cnt    <= '0;
`ifdef MOORE_PATTERN_TX_PARITY_EN
                        r_parity <= ^bus.Data;
`endif
                        r_state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_shreg <= r_shreg << 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_cnt  <= '0;
                        r_gcnt <= '0;
`ifdef MOORE_PATTERN_TX_PARITY_EN
                        r_state <= ST_PARITY;
`else
                        r_state <= POST_WORD;
`endif
                    end
                end
`ifdef MOORE_PATTERN_TX_PARITY_EN
                ST_PARITY: r_state <= POST_WORD;
`endif
                ST_GAP: begin
                    if (r_gcnt == GAP_LAST) r_state <= ST_DONE;
                    else                    r_gcnt  <= r_gcnt + 1'b1;
                end
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs depend on the state registers only.
    always_comb begin
        w_ready = 1'b0;
        w_out   = 1'b0;
        w_frame = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            ST_IDLE:  w_ready = 1'b1;
            ST_SHIFT: begin
                w_out   = r_shreg[WIDTH-1];
                w_frame = 1'b1;
            end
`ifdef MOORE_PATTERN_TX_PARITY_EN
            ST_PARITY: begin
                w_out   = r_parity;
                w_frame = 1'b1;
            end
`endif
            ST_DONE:  w_done = 1'b1;
            default:  w_out  = 1'b0;
        endcase
    end

    assign bus.Ready  = w_ready;
    assign bus.Output = w_out;
    assign bus.Frame  = w_frame;
    assign bus.Done   = w_done;

endmodule
